// File: rtl/rb_pkg.sv
// rb_pkg: shared types and constants for the ring_buffer FIFO.
//   rb_data_t     - default stored word type (8 bits)
//   DEFAULT_DEPTH - default number of storage entries
//   ptr_width()   - pointer width: index bits plus one wrap bit
package rb_pkg;

  typedef logic [7:0] rb_data_t;

  localparam int DEFAULT_DEPTH = 16;

  // The extra MSB lets equal indices be told apart as full or empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rb_if.sv
// rb_if: valid/ready streaming bundle used on both sides of ring_buffer.
//   data  - payload word (data_t)
//   valid - producer has a word on data
//   ready - consumer can take the word
// Modports: sink (data/valid in, ready out), source (data/valid out, ready in).
interface rb_if
  import rb_pkg::*;
#(
  parameter type data_t = rb_data_t
) ();

  data_t data;
  logic  valid;
  logic  ready;

  modport sink   (input data, input valid, output ready);
  modport source (output data, output valid, input ready);

endinterface

// File: rtl/rb_ptr.sv
// rb_ptr: wrapping pointer counter for the ring_buffer.
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset, clears the pointer
//   inc   - advance the pointer by one this cycle
//   ptr   - registered pointer value, wraps modulo 2**W
module rb_ptr #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_r;

  // Pointer register; natural overflow gives the modulo-2*DEPTH wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= {W{1'b0}};
    end else if (inc) begin
      ptr_r <= ptr_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/ring_buffer.sv
// ring_buffer: single-clock first-word-fall-through FIFO with valid/ready
// streaming on both sides.
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset; discards all stored words
//   full  - DEPTH words stored
//   empty - no words stored
//   i_bus - rb_if sink: write side (data/valid in, ready out)
//   o_bus - rb_if source: read side (data/valid out, ready in)
// Build option: RING_BUFFER_OVERWRITE_EN ties i_bus.ready high and lets a
// write while full replace the oldest entry instead of being refused.
module ring_buffer
  import rb_pkg::*;
#(
  parameter type data_t = rb_data_t,
  parameter int  DEPTH  = DEFAULT_DEPTH
) (
  input  logic     clk,
  input  logic     rst_n,
  output logic     full,
  output logic     empty,
  rb_if.sink       i_bus,
  rb_if.source     o_bus
);

  localparam int PW = ptr_width(DEPTH);
  localparam int IW = PW - 1;

  logic [PW-1:0] wr_ptr_s;
  logic [PW-1:0] rd_ptr_s;
  logic          full_s;
  logic          empty_s;
  logic          wr_en_s;
  logic          rd_en_s;
  logic          rd_fire_s;

  data_t mem_r [DEPTH];

  // Flags depend only on the registered pointers.
  assign empty_s = (wr_ptr_s == rd_ptr_s);
  assign full_s  = (wr_ptr_s[IW-1:0] == rd_ptr_s[IW-1:0]) &&
                   (wr_ptr_s[IW] != rd_ptr_s[IW]);

  assign full  = full_s;
  assign empty = empty_s;

`ifdef RING_BUFFER_OVERWRITE_EN
  assign i_bus.ready = 1'b1;
`else
  assign i_bus.ready = ~full_s;
`endif

  assign o_bus.valid = ~empty_s;
  assign o_bus.data  = mem_r[rd_ptr_s[IW-1:0]];

  // Handshake decode; valid gates ready so an unknown ready while empty is inert.
  always_comb begin
    wr_en_s   = 1'b0;
    rd_fire_s = 1'b0;
    rd_en_s   = 1'b0;
    rd_fire_s = (~empty_s) & (o_bus.ready === 1'b1);
`ifdef RING_BUFFER_OVERWRITE_EN
    wr_en_s = (i_bus.valid === 1'b1);
    // A write into a full buffer drops the oldest word by advancing the read side.
    if (wr_en_s && full_s) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = rd_fire_s;
    end
`else
    wr_en_s = (i_bus.valid === 1'b1) & ~full_s;
    rd_en_s = rd_fire_s;
`endif
  end

  // Storage is deliberately left out of reset; pointers alone define contents.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_s[IW-1:0]] <= i_bus.data;
    end
  end

  rb_ptr #(.W(PW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wr_en_s),
    .ptr   (wr_ptr_s)
  );

  rb_ptr #(.W(PW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rd_en_s),
    .ptr   (rd_ptr_s)
  );

endmodule

// File: tb/tb_ring_buffer.sv
// tb_ring_buffer: directed, scoreboard-checked bench for ring_buffer
// (DEPTH=16, 8-bit words). Honours RING_BUFFER_OVERWRITE_EN.
module tb_ring_buffer;
  import rb_pkg::*;

  localparam int DEPTH = 16;
`ifdef RING_BUFFER_OVERWRITE_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic full;
  logic empty;

  rb_if #(.data_t(rb_data_t)) i_bus ();
  rb_if #(.data_t(rb_data_t)) o_bus ();

  ring_buffer #(.data_t(rb_data_t), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .full  (full),
    .empty (empty),
    .i_bus (i_bus),
    .o_bus (o_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input logic wv, input logic [7:0] wd, input logic rr);
    bit do_rd;
    bit do_wr;
    bit was_full;
    i_bus.valid = wv;
    i_bus.data  = wd;
    o_bus.ready = rr;
    #1;
    chk("empty", {31'd0, empty}, {31'd0, (sb.size() == 0)});
    chk("full", {31'd0, full}, {31'd0, (sb.size() == DEPTH)});
    chk("o_valid", {31'd0, o_bus.valid}, {31'd0, (sb.size() != 0)});
    chk("i_ready", {31'd0, i_bus.ready}, {31'd0, (OVR || sb.size() < DEPTH)});
    do_rd    = (rr === 1'b1) && (sb.size() != 0);
    was_full = (sb.size() == DEPTH);
    do_wr    = (wv === 1'b1) && (OVR || !was_full);
    if (do_rd) chk("rd_data", {24'd0, o_bus.data}, {24'd0, sb[0]});
    @(posedge clk);
    if (do_rd) void'(sb.pop_front());
    if (do_wr && was_full && !do_rd) void'(sb.pop_front());
    if (do_wr) sb.push_back(wd);
    @(negedge clk);
  endtask

  task automatic do_reset();
    i_bus.valid = 1'b0;
    i_bus.data  = 8'h00;
    o_bus.ready = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    i_bus.valid = 1'b0;
    i_bus.data  = 8'h00;
    o_bus.ready = 1'b0;

    // Power-on reset
    repeat (2) @(negedge clk);
    chk("por_empty", {31'd0, empty}, 32'd1);
    chk("por_full", {31'd0, full}, 32'd0);
    chk("por_o_valid", {31'd0, o_bus.valid}, 32'd0);
    chk("por_i_ready", {31'd0, i_bus.ready}, 32'd1);
    rst_n = 1'b1;

    // Unknown ready while empty must not disturb state
    step(1'b0, 8'h00, 1'bx);
    step(1'b0, 8'h00, 1'b0);

    // Write then reset mid-operation; reset acts without a clock edge
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'hBB, 1'b0);
    i_bus.valid = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("async_rst_empty", {31'd0, empty}, 32'd1);
    chk("async_rst_o_valid", {31'd0, o_bus.valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step(1'b0, 8'h00, 1'b0);
    chk("post_rst_empty", {31'd0, empty}, 32'd1);

    // Basic FIFO with first-word fall-through
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'hBB, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("fwft_data", {24'd0, o_bus.data}, 32'h0000_00AA);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("basic_empty", {31'd0, empty}, 32'd1);

    // Fill to DEPTH, then a 17th write
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0);
    chk("fill_full", {31'd0, full}, 32'd1);
    step(1'b1, 8'h10, 1'b0);
    // Simultaneous read and write while full
    step(1'b1, 8'h11, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("drain_empty", {31'd0, empty}, 32'd1);

    // Wrap with 8 resident words and simultaneous traffic
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h30 + i), 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("wrap_empty", {31'd0, empty}, 32'd1);

`ifdef RING_BUFFER_OVERWRITE_EN
    // Overwrite oldest when full
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    chk("ovr_full", {31'd0, full}, 32'd1);
    chk("ovr_head", {24'd0, o_bus.data}, 32'h0000_0001);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("ovr_empty", {31'd0, empty}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
